alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Command buffer directly upstream of the single-cycle ALU.
- Accepts operand/command triples from the sequencer on a valid/ready handshake and stores them in a small FIFO.
- Presents the head entry to the ALU only in cycles where the ALU reports ready; in all other cycles it drives OP_NOP.
- Decouples the producer from the ALU's READY/BUSY alternation, so back-to-back producer writes are not lost.

Parameters:
- DATA_W, 32, operand width; must match ALU operand width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted). Release is synchronised externally.
- in_a  in  DATA_W  first operand from producer.
- in_b  in  DATA_W  second operand from producer.
- in_cmd  in  2  command code (OP_NOP/OP_ADD/OP_SUB).
- in_valid  in  1  producer has a command.
- in_ready  out  1  queue can accept; equals !full.
- alu_ready  in  1  ALU o_ready.
- alu_a  out  DATA_W  to ALU i_a.
- alu_b  out  DATA_W  to ALU i_b.
- alu_cmd  out  2  to ALU i_cmd.
- issue  out  1  a queued entry is consumed by the ALU this cycle.
- level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set when in_valid is high while full.

Behaviour:
- Storage: DEPTH entries of {a, b, cmd}.
  - Read/write pointers are clog2(DEPTH)+1 bits with a wrap bit.
  - empty = pointers equal; full = index bits equal and wrap bits differ.
- Reset (reset=0, asynchronous): pointers 0, level=0, overflow=0, in_ready=1, issue=0, alu_cmd=OP_NOP, alu_a=alu_b=0.
  - Memory contents are don't-care.
  - Reset mid-operation discards all queued entries; nothing partial is issued after release.
- Push: in_valid && in_ready at a rising edge writes the entry at wptr and increments wptr.
  - in_cmd is stored verbatim; OP_NOP entries are queued and issued like any other entry.
- Issue (combinational from registered state): issue = alu_ready && !empty.
  - When issue=1: alu_a/alu_b/alu_cmd = head entry. The ALU samples them at the next edge, at which rptr increments.
  - When issue=0: alu_cmd=OP_NOP, alu_a=alu_b=0.
- Latency: an entry pushed at edge N is first visible at the head after edge N. With an empty queue and ALU ready, it is issued in cycle N+1. No same-cycle bypass.
- Throughput: one issue per ALU READY cycle, i.e. at most one every 2 cycles given the ALU's READY/BUSY alternation.
- Simultaneous push and pop:
  - Not full: both occur; level unchanged.
  - Full: push refused (in_ready=0 during that cycle regardless of the pop); pop occurs; in_ready rises next cycle.
- Empty and push in the same cycle: push only; issue=0 that cycle.
- Overflow: set on any edge where in_valid=1 and full=1. The data is dropped. Cleared only by reset.
- Wrap-around: pointers wrap modulo 2*DEPTH; ordering is strictly FIFO across wrap.
- level = wptr - rptr (modular, same width); registered arithmetic only, no extra state.

Decomposition:
- Shared package alu_pkg:
  - OP_NOP=2'h0, OP_ADD=2'h1, OP_SUB=2'h2.
  - Command width 2, default DATA_W 32.
  - Packed entry typedef {a, b, cmd}. The ALU uses the same opcode constants.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/level).
- alu_issue_queue instantiates sync_fifo and adds the issue gating, NOP substitution and overflow flag.

Test Plan:
- Reset then idle with alu_ready=1 -> in_ready=1, level=0, issue=0, alu_cmd=OP_NOP every cycle; overflow=0.
- Push {a=5, b=7, ADD} into empty queue, alu_ready=1 -> issue=1 in next cycle with alu_a=5, alu_b=7, alu_cmd=OP_ADD; level 1->0; ALU o_result=12 after its BUSY cycle.
- alu_ready held 0, push 4 entries (a=1..4, b=10) then a 5th -> in_ready=0 after 4th; 5th dropped; overflow=1; level=4. Release alu_ready -> issue order a=1,2,3,4.
- Full queue, alu_ready=1 and in_valid=1 same cycle -> pop occurs, push refused, level 4->3, in_ready=1 next cycle; the 5th entry accepted then.
- Stream 10 entries through DEPTH=4 with alu_ready toggling 1/0 -> all 10 issued in order across pointer wrap; no issue while alu_ready=0.
- Assert reset=0 asynchronously mid-stream with level=3 -> level, in_ready, issue and alu_cmd reach reset values before the next clock edge; no stale entry issued after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants and entry layout for the ALU and its issue queue.
// The ALU decodes the same OP_* values that the queue stores and forwards.
package alu_pkg;

    localparam int CMD_W      = 2;
    localparam int DEF_DATA_W = 32;

    localparam logic [CMD_W-1:0] OP_NOP = 2'h0;
    localparam logic [CMD_W-1:0] OP_ADD = 2'h1;
    localparam logic [CMD_W-1:0] OP_SUB = 2'h2;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] a;
        logic [DEF_DATA_W-1:0] b;
        logic [CMD_W-1:0]      cmd;
    } entry_t;

    // Width of a flat {a, b, cmd} entry for a given operand width
    function automatic int entry_w(input int dw);
        return 2 * dw + CMD_W;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; level is the pointer difference.
// Push while full and pop while empty are ignored internally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                     (r_wptr[AW] != r_rptr[AW]);
    assign o_level = r_wptr - r_rptr;
    assign o_dout  = r_mem[r_rptr[AW-1:0]];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointer advance; reset discards every queued entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Command buffer in front of the single-cycle ALU: queues producer
// commands and hands the head over only in ALU-ready cycles, else NOP.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      in_a,
    input  logic [DATA_W-1:0]      in_b,
    input  logic [1:0]             in_cmd,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   alu_ready,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [1:0]             alu_cmd,
    output logic                   issue,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int EW = entry_w(DATA_W);

    logic [EW-1:0] w_din;
    logic [EW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          r_overflow;

    assign w_din    = {in_a, in_b, in_cmd};
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign issue    = alu_ready && !w_empty;
    assign overflow = r_overflow;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (issue),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // Present the head only when it is consumed; otherwise a clean NOP
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cmd = OP_NOP;
        if (issue) begin
            alu_a   = w_head[EW-1 -: DATA_W];
            alu_b   = w_head[EW-1-DATA_W -: DATA_W];
            alu_cmd = w_head[CMD_W-1:0];
        end
    end

    // Sticky record of any producer attempt against a full queue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (in_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: per-cycle vector table plus
// hand-written stream, wrap and asynchronous-reset sequences.
module tb_alu_issue_queue;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_cmd;
    logic        in_valid;
    logic        in_ready;
    logic        alu_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_cmd;
    logic        issue;
    logic [2:0]  level;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    alu_issue_queue #(.DATA_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cmd    (in_cmd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ready (alu_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cmd   (alu_cmd),
        .issue     (issue),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  c;
        logic        rdy;
        logic        e_inr;
        logic        e_iss;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [1:0]  e_c;
        logic [2:0]  e_lvl;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] a,
        input logic [31:0] b, input logic [1:0] c, input logic rdy,
        input logic e_inr, input logic e_iss, input logic [31:0] e_a,
        input logic [31:0] e_b, input logic [1:0] e_c,
        input logic [2:0] e_lvl, input logic e_ovf);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.c = c; r.rdy = rdy;
        r.e_inr = e_inr; r.e_iss = e_iss; r.e_a = e_a; r.e_b = e_b;
        r.e_c = e_c; r.e_lvl = e_lvl; r.e_ovf = e_ovf;
        return r;
    endfunction

    task automatic check_all(input string tag, input logic e_inr,
        input logic e_iss, input logic [31:0] e_a, input logic [31:0] e_b,
        input logic [1:0] e_c, input logic [2:0] e_lvl, input logic e_ovf);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_inr));
        chk({tag, ".issue"},    32'(issue),    32'(e_iss));
        chk({tag, ".alu_a"},    alu_a,         e_a);
        chk({tag, ".alu_b"},    alu_b,         e_b);
        chk({tag, ".alu_cmd"},  32'(alu_cmd),  32'(e_c));
        chk({tag, ".level"},    32'(level),    32'(e_lvl));
        chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
    endtask

    int sent;
    int got;
    int mlevel;
    int cyc;
    logic exp_iss;

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cmd = OP_NOP; alu_ready = 1'b1;

        // row: v a b c rdy | inr iss a b cmd lvl ovf
        vecs[0]  = mk(0, 0, 0, OP_NOP, 1, 1, 0, 0, 0, OP_NOP, 0, 0);
        vecs[1]  = mk(0, 0, 0, OP_NOP, 1, 1, 0, 0, 0, OP_NOP, 0, 0);
        vecs[2]  = mk(1, 5, 7, OP_ADD, 1, 1, 0, 0, 0, OP_NOP, 0, 0);
        vecs[3]  = mk(0, 0, 0, OP_NOP, 1, 1, 1, 5, 7, OP_ADD, 1, 0);
        vecs[4]  = mk(0, 0, 0, OP_NOP, 1, 1, 0, 0, 0, OP_NOP, 0, 0);
        vecs[5]  = mk(1, 1, 10, OP_ADD, 0, 1, 0, 0, 0, OP_NOP, 0, 0);
        vecs[6]  = mk(1, 2, 10, OP_SUB, 0, 1, 0, 0, 0, OP_NOP, 1, 0);
        vecs[7]  = mk(1, 3, 10, OP_NOP, 0, 1, 0, 0, 0, OP_NOP, 2, 0);
        vecs[8]  = mk(1, 4, 10, OP_ADD, 0, 1, 0, 0, 0, OP_NOP, 3, 0);
        vecs[9]  = mk(1, 5, 10, OP_ADD, 0, 0, 0, 0, 0, OP_NOP, 4, 0);
        vecs[10] = mk(0, 0, 0, OP_NOP, 0, 0, 0, 0, 0, OP_NOP, 4, 1);
        vecs[11] = mk(1, 6, 10, OP_SUB, 1, 0, 1, 1, 10, OP_ADD, 4, 1);
        vecs[12] = mk(1, 6, 10, OP_SUB, 1, 1, 1, 2, 10, OP_SUB, 3, 1);
        vecs[13] = mk(0, 0, 0, OP_NOP, 0, 1, 0, 0, 0, OP_NOP, 3, 1);
        vecs[14] = mk(0, 0, 0, OP_NOP, 1, 1, 1, 3, 10, OP_NOP, 3, 1);
        vecs[15] = mk(0, 0, 0, OP_NOP, 1, 1, 1, 4, 10, OP_ADD, 2, 1);
        vecs[16] = mk(0, 0, 0, OP_NOP, 1, 1, 1, 6, 10, OP_SUB, 1, 1);
        vecs[17] = mk(0, 0, 0, OP_NOP, 1, 1, 0, 0, 0, OP_NOP, 0, 1);

        // Outputs held at reset values while reset is asserted
        repeat (2) @(posedge clk);
        #1;
        check_all("rst", 1, 0, 0, 0, OP_NOP, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Table: drive after the edge, check settled outputs before the next
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            in_valid = vecs[i].v; in_a = vecs[i].a; in_b = vecs[i].b;
            in_cmd = vecs[i].c; alu_ready = vecs[i].rdy;
            #3;
            check_all($sformatf("vec%0d", i), vecs[i].e_inr, vecs[i].e_iss,
                      vecs[i].e_a, vecs[i].e_b, vecs[i].e_c,
                      vecs[i].e_lvl, vecs[i].e_ovf);
        end

        // Stream 10 entries across pointer wrap with alu_ready toggling
        sent = 0; got = 0; mlevel = 0; cyc = 0;
        while (got < 10 && cyc < 200) begin
            @(posedge clk);
            #1;
            in_valid  = (sent < 10);
            in_a      = 32'(100 + sent);
            in_b      = 32'(sent);
            in_cmd    = 2'(sent % 3);
            alu_ready = cyc[0];
            #3;
            exp_iss = alu_ready && (mlevel != 0);
            chk("str.level", 32'(level), 32'(mlevel));
            chk("str.issue", 32'(issue), 32'(exp_iss));
            if (issue && exp_iss) begin
                chk("str.a",   alu_a,         32'(100 + got));
                chk("str.b",   alu_b,         32'(got));
                chk("str.cmd", 32'(alu_cmd),  32'(got % 3));
                got++;
            end
            if (in_valid && (mlevel < 4)) sent++;
            mlevel = mlevel + ((in_valid && (mlevel < 4)) ? 1 : 0)
                            - (exp_iss ? 1 : 0);
            cyc++;
        end
        chk("str.count", 32'(got), 32'd10);

        // Fill to level 3 with the ALU stalled
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; in_a = 32'(200 + i); in_b = 32'd9;
            in_cmd = OP_ADD; alu_ready = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; alu_ready = 1'b1;
        #1;
        chk("pre.level", 32'(level), 32'd3);
        chk("pre.issue", 32'(issue), 32'd1);
        chk("pre.a", alu_a, 32'd200);

        // Asynchronous reset mid-cycle, checked before the next edge
        #1;
        reset = 1'b0;
        #1;
        check_all("arst", 1, 0, 0, 0, OP_NOP, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Nothing stale may issue after release
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #4;
            check_all($sformatf("post%0d", i), 1, 0, 0, 0, OP_NOP, 0, 0);
        end

        // Fresh entry flows normally after reset
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_a = 32'd42; in_b = 32'd1; in_cmd = OP_SUB;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #3;
        check_all("fresh", 1, 1, 42, 1, OP_SUB, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
